// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared definitions for the EX-stage ALU control with the multi-cycle mul/div sequencer.
// Holds ALU control codes, R-type funct values, ALUOp encodings and FSM/op enums.
package alu_ctrl_pkg;

    // ALU control codes driven to the EX-stage ALU
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_MULDIV = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLT    = 4'b0111;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Ordered so that funct[1:0] of the long ops casts directly
    typedef enum logic [1:0] {
        OpMult,
        OpMultu,
        OpDiv,
        OpDivu
    } long_op_e;

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// Bus between the EX stage and the ALU control / mul-div sequencer.
// master: pipeline side (drives instruction fields and operands, receives control/stall/HI-LO).
// slave:  alu_ctrl_muldiv.
interface alu_ctrl_muldiv_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
);
    logic              valid_i;
    logic [1:0]        ALUOp_i;
    logic [5:0]        funct_i;
    logic [WIDTH-1:0]  rs_data_i;
    logic [WIDTH-1:0]  rt_data_i;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              stall_o;
    logic              hilo_sel_o;
    logic [WIDTH-1:0]  hilo_o;
    logic              done_o;

    modport master (
        output valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i,
        input  ALUCtrl_o, stall_o, hilo_sel_o, hilo_o, done_o
    );

    modport slave (
        input  valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i,
        output ALUCtrl_o, stall_o, hilo_sel_o, hilo_o, done_o
    );
endinterface

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath, one step per cycle.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       load operands, counter = WIDTH-1
//   step_i        perform one iteration
//   is_div_i      operation type captured on start (1 = divide)
//   mq_init_i     multiplier (mul) or dividend (div) magnitude
//   opnd_i        multiplicand (mul) or divisor (div) magnitude
//   hi_o, lo_o    mul: product upper/lower half; div: remainder / quotient
//   last_o        current step is the final iteration
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] mq_init_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        addend  = mq_q[0] ? opnd_q : '0;
        add_sum = {1'b0, acc_q} + {1'b0, addend};
        // Partial remainder is always below the divisor, so WIDTH+1 bits hold the shift and
        // the top bit of the trial difference is the borrow.
        shifted = {acc_q, mq_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};

        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;

        if (start_i) begin
            acc_d    = '0;
            mq_d     = mq_init_i;
            opnd_d   = opnd_i;
            is_div_d = is_div_i;
            cnt_d    = CNT_W'(WIDTH - 1);
        end else if (step_i) begin
            if (is_div_q) begin
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Shift right of {acc, multiplier} with the carry of the conditional add
                acc_d = add_sum[WIDTH:1];
                mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hi_o   = acc_q;
    assign lo_o   = mq_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: decodes ALUOp/funct into the ALU control code and sequences
// mult/multu/div/divu on an iterative unit, holding the pipeline until HI/LO are written.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    alu_ctrl_muldiv_if.slave: valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i in;
//          ALUCtrl_o, stall_o, hilo_sel_o, hilo_o, done_o out
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    alu_ctrl_muldiv_if.slave bus
);
    // ---------------- decode ----------------
    logic [3:0] code;
    logic       is_long;
    logic       is_mfhilo;

    always_comb begin
        code      = ALU_ADD;
        is_long   = 1'b0;
        is_mfhilo = 1'b0;
        case (bus.ALUOp_i)
            ALUOP_ADD, ALUOP_ADDI: code = ALU_ADD;
            ALUOP_SUB:             code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (bus.funct_i)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    FUNCT_SLT: code = ALU_SLT;
                    FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                        code    = ALU_MULDIV;
                        is_long = 1'b1;
                    end
                    FUNCT_MFHI, FUNCT_MFLO: begin
                        code      = ALU_ADD;
                        is_mfhilo = 1'b1;
                    end
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    // ---------------- sequencer ----------------
    state_e           state_q;
    long_op_e         op_q;
    logic             neg_a_q, neg_b_q, div0_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             start;
    logic             signed_op;
    logic             op_is_div;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic             iter_last;

    // Reset wins over a start presented in the same cycle
    assign start     = (state_q == StIdle) && bus.valid_i && is_long && !rst_i;
    assign signed_op = !bus.funct_i[0];
    assign op_is_div = bus.funct_i[1];
    assign rs_mag    = (signed_op && bus.rs_data_i[WIDTH-1]) ? -bus.rs_data_i : bus.rs_data_i;
    assign rt_mag    = (signed_op && bus.rt_data_i[WIDTH-1]) ? -bus.rt_data_i : bus.rt_data_i;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start),
        .step_i    (state_q == StBusy),
        .is_div_i  (op_is_div),
        .mq_init_i (op_is_div ? rs_mag : rt_mag),
        .opnd_i    (op_is_div ? rt_mag : rs_mag),
        .hi_o      (iter_hi),
        .lo_o      (iter_lo),
        .last_o    (iter_last)
    );

    // Sign fix applied to the magnitude result while in DONE
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    always_comb begin
        prod_raw = {iter_hi, iter_lo};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
        if (op_q == OpMult || op_q == OpMultu) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else begin
            // With a zero divisor every step shifts a dividend bit into the remainder, so the
            // remainder path already yields the dividend; only the quotient is overridden.
            hi_fix = neg_a_q ? -iter_hi : iter_hi;
            if (div0_q) begin
                lo_fix = '1;
            end else begin
                lo_fix = (neg_a_q ^ neg_b_q) ? -iter_lo : iter_lo;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= OpMult;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= long_op_e'(bus.funct_i[1:0]);
                        neg_a_q <= signed_op && bus.rs_data_i[WIDTH-1];
                        neg_b_q <= signed_op && bus.rt_data_i[WIDTH-1];
                        div0_q  <= (bus.rt_data_i == '0);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (iter_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.ALUCtrl_o  = CTRL_W'(code);
    assign bus.stall_o    = start || (state_q == StBusy);
    assign bus.done_o     = done_q;
    assign bus.hilo_sel_o = is_mfhilo;
    assign bus.hilo_o     = !is_mfhilo ? '0 : ((bus.funct_i == FUNCT_MFHI) ? hi_q : lo_q);

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Successor ALU control for the EX stage. It decodes ALUOp_i and funct_i into the ALU control code, and generalises the datapath width. It adds a multi-cycle sequencer for mult/multu/div/divu, with architectural HI/LO registers and a pipeline stall interlock. The single-cycle ops keep the existing encoding; long ops run in an internal iterative shift-add/restoring unit.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits
CTRL_W, 4, ALU control code width
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  instruction in EX is real (not a bubble)
ALUOp_i  in  2  00 add (lw/sw/addi), 01 sub (beq), 10 R-type, 11 add
funct_i  in  6  R-type funct field
rs_data_i  in  WIDTH  operand A / dividend / multiplicand
rt_data_i  in  WIDTH  operand B / divisor / multiplier
ALUCtrl_o  out  CTRL_W  ALU control code
stall_o  out  1  hold IF/ID/EX; insert bubble into MEM
hilo_sel_o  out  1  1 = mfhi/mflo result is on hilo_o (forward to EX result mux)
hilo_o  out  WIDTH  HI for mfhi, LO for mflo
done_o  out  1  one-cycle pulse when HI/LO are written

Behaviour:
- Decode (combinational), with ALUOp=10 and these funct values:
  100000 -> 0010 (add); 100010 -> 0110 (sub); 100100 -> 0000 (and); 100101 -> 0001 (or); 101010 -> 0111 (slt).
  011000 / 011001 / 011010 / 011011 (mult/multu/div/divu) -> 0011.
  010000 (mfhi) / 010010 (mflo) -> 0010, with hilo_sel_o=1.
  Any other funct -> 0010.
- ALUOp decode: 00 -> 0010; 01 -> 0110; 11 -> 0010.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on valid_i with a long op: latch magnitudes, sign flags and op type; counter = WIDTH-1; go to BUSY. stall_o=1 in this same cycle (combinational).
- BUSY: one iteration per cycle.
  - Multiply: conditional add, then shift right of the {acc, multiplier} 2*WIDTH register.
  - Divide: restoring step (shift left, trial subtract, set quotient bit).
  - stall_o=1 throughout. Leave BUSY when the counter reaches 0, after that cycle's iteration.
- DONE (one cycle):
  - Apply sign fix, then write HI/LO.
  - Multiply: HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder. Remainder takes the dividend's sign.
  - done_o=1 and stall_o=0, so the held instruction retires. Next state is IDLE.
  - The still-presented long op must not restart.
- Total stall: WIDTH+1 cycles (33 for WIDTH=32). HI/LO are visible from the cycle after DONE.
- Divide by zero: HI = dividend, LO = all ones, with normal timing.
- Signed MIN / -1: LO = MIN, HI = 0.
- mfhi/mflo while in BUSY or at BUSY entry: stall_o=1 until DONE, then read the new value.
- A long op arriving while in BUSY is impossible, because the pipeline is stalled.
- valid_i=0 never starts an op. Decode outputs are still driven.
- Reset, including mid-operation:
  - Next edge gives state IDLE, counter 0, HI=LO=0.
  - Outputs: stall_o=0, done_o=0, hilo_sel_o=0, hilo_o=0, ALUCtrl_o=0010 (for ALUOp 00).
- Reset has priority over start.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_MULDIV, ALU_SUB, ALU_SLT).
  - Funct constants.
  - ALUOp constants.
  - FSM state enum.
- One sub-module, muldiv_iter: the iterative datapath with start/op/operand inputs and a result/last-iteration output.
- Decode and FSM live in the top.

Test Plan:
- ALUOp=10, each funct 100000/100010/100100/100101/101010/000000 -> 0010/0110/0000/0001/0111/0010; stall_o=0 always.
- mult, rs=-3, rt=7 (WIDTH=32) -> stall_o high for 33 cycles; done_o pulses; HI=FFFFFFFF, LO=FFFFFFEB; then mflo returns FFFFFFEB with hilo_sel_o=1.
- div, rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF. divu, rs=7, rt=0 -> LO=FFFFFFFF, HI=00000007.
- multu 0xFFFFFFFF*0xFFFFFFFF, then mfhi issued immediately after -> mfhi is held until DONE and reads HI=FFFFFFFE; LO=00000001.
- rst_i asserted at iteration 10 of a div -> next cycle state IDLE, stall_o=0, HI=LO=0; the following mult runs the full 33 cycles.
- A long op held with valid_i=1 through DONE -> exactly one done_o pulse, no restart; the same funct with valid_i=0 -> no stall.
